// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef logic [31:0] instruction_type;

    typedef struct packed {
        logic [31:0]     pc;
        instruction_type instruction;
        logic            valid;
    } if_id_type;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_program_counter.sv
// PC register and next-fetch-address mux; pc_next doubles as the instruction memory address.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_next,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q + PC_STEP;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (branch_taken) begin
            pc_d = word_align(branch_target);
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    assign pc_next = pc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives a 1-cycle-latency instruction memory and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    logic [31:0] pc_q;
    logic        fetch_valid_q;
    logic        fetch_valid_d;
    if_id_type   if_id_q;
    if_id_type   if_id_d;

    program_counter #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_program_counter (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (imem_addr),
        .pc_q          (pc_q)
    );

    // The redirect target is presented to memory in the branch cycle itself, so the
    // following word is on-path; only the first word after reset is treated as a bubble.
    always_comb begin
        fetch_valid_d = 1'b1;
        if_id_d       = if_id_q;
        if (branch_taken) begin
            if_id_d = '{pc: pc_q, instruction: NOP_INSTRUCTION, valid: 1'b0};
        end else if (!stall) begin
            if_id_d.pc          = pc_q;
            if_id_d.instruction = fetch_valid_q ? imem_rdata : NOP_INSTRUCTION;
            if_id_d.valid       = fetch_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            if_id_q       <= '{pc: RESET_PC, instruction: NOP_INSTRUCTION, valid: 1'b0};
        end else begin
            fetch_valid_q <= fetch_valid_d;
            if_id_q       <= if_id_d;
        end
    end

    assign if_id_pc          = if_id_q.pc;
    assign if_id_instruction = if_id_q.instruction;
    assign if_id_valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: rule-level reference model checked every cycle plus literal checkpoints.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;

    logic        reset2 = 1'b1;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic [31:0] if_id_pc2;
    logic [31:0] if_id_instruction2;
    logic        if_id_valid2;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8),
        .PC_STEP  (32'd4)
    ) dut_wrap (
        .clk               (clk),
        .reset             (reset2),
        .stall             (1'b0),
        .branch_taken      (1'b0),
        .branch_target     (32'h0),
        .imem_addr         (imem_addr2),
        .imem_rdata        (imem_rdata2),
        .if_id_pc          (if_id_pc2),
        .if_id_instruction (if_id_instruction2),
        .if_id_valid       (if_id_valid2)
    );

    // Memory where every word holds its own byte address, one cycle read latency.
    always @(posedge clk) begin
        imem_rdata  <= imem_addr;
        imem_rdata2 <= imem_addr2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: fetch address and the IF/ID contents from the behavioural rules.
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic        m_fv;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_ins;
    logic        m_if_v;

    always @(negedge clk) begin
        logic [31:0] a;
        if (reset)             a = 32'h0;
        else if (branch_taken) a = branch_target & ~32'h3;
        else if (stall)        a = m_pc;
        else                   a = m_pc + 32'd4;
        if (m_known) begin
            chk("mdl_imem_addr", imem_addr, a);
            chk("mdl_if_id_pc", if_id_pc, m_if_pc);
            chk("mdl_if_id_instruction", if_id_instruction, m_if_ins);
            chk("mdl_if_id_valid", {31'b0, if_id_valid}, {31'b0, m_if_v});
        end
        if (reset) begin
            m_if_pc  = 32'h0;
            m_if_ins = NOP;
            m_if_v   = 1'b0;
            m_fv     = 1'b0;
            m_known  = 1'b1;
        end else if (m_known) begin
            if (branch_taken) begin
                m_if_pc  = m_pc;
                m_if_ins = NOP;
                m_if_v   = 1'b0;
            end else if (!stall) begin
                m_if_pc  = m_pc;
                m_if_ins = m_fv ? m_pc : NOP;
                m_if_v   = m_fv;
            end
            m_fv = 1'b1;
        end
        m_pc = a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] pc, input logic [31:0] ins, input logic v);
        chk({name, "_pc"}, if_id_pc, pc);
        chk({name, "_ins"}, if_id_instruction, ins);
        chk({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    endtask

    initial begin
        tick();
        tick();
        chk_ifid("reset", 32'h0, NOP, 1'b0);
        chk("reset_addr", imem_addr, 32'h0);

        reset = 1'b0;
        #1 chk("run_addr0", imem_addr, 32'h4);
        tick();
        chk_ifid("run0", 32'h0, NOP, 1'b0);
        chk("run_addr1", imem_addr, 32'h8);
        tick();
        chk_ifid("run1", 32'h4, 32'h4, 1'b1);
        chk("run_addr2", imem_addr, 32'hC);
        tick();
        chk_ifid("run2", 32'h8, 32'h8, 1'b1);

        stall = 1'b1;
        #1 chk("stall_addr", imem_addr, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall_hold", 32'h8, 32'h8, 1'b1);
            chk("stall_hold_addr", imem_addr, 32'hC);
        end
        stall = 1'b0;
        #1 chk("release_addr", imem_addr, 32'h10);
        tick();
        chk_ifid("release", 32'hC, 32'hC, 1'b1);
        tick();

        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        #1 chk("branch_addr", imem_addr, 32'h100);
        tick();
        chk_ifid("branch_flush", 32'h14, NOP, 1'b0);
        branch_taken = 1'b0;
        #1 chk("branch_next_addr", imem_addr, 32'h104);
        tick();
        chk_ifid("branch_target", 32'h100, 32'h100, 1'b1);

        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h0000_0200;
        #1 chk("brstall_addr", imem_addr, 32'h200);
        tick();
        chk_ifid("brstall_flush", 32'h104, NOP, 1'b0);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        chk_ifid("brstall_target", 32'h200, 32'h200, 1'b1);
        tick();

        stall = 1'b1;
        tick();
        chk_ifid("pre_reset_stall", 32'h204, 32'h204, 1'b1);
        reset = 1'b1;
        #1 chk("reset_stall_addr", imem_addr, 32'h0);
        tick();
        chk_ifid("reset_stall", 32'h0, NOP, 1'b0);
        reset = 1'b0;
        stall = 1'b0;
        repeat (4) tick();

        tick();
        chk("wrap_reset_addr", imem_addr2, 32'hFFFF_FFF8);
        reset2 = 1'b0;
        #1 chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr2, 32'h0000_0000);
        chk("wrap_ifid0_pc", if_id_pc2, 32'hFFFF_FFF8);
        chk("wrap_ifid0_valid", {31'b0, if_id_valid2}, 32'h0);
        tick();
        chk("wrap_ifid1_pc", if_id_pc2, 32'hFFFF_FFFC);
        chk("wrap_ifid1_ins", if_id_instruction2, 32'hFFFF_FFFC);
        chk("wrap_ifid1_valid", {31'b0, if_id_valid2}, 32'h1);
        chk("wrap_addr2", imem_addr2, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
